// File: rtl/uart_tx_stream.sv
// uart_tx_stream: UART transmitter with an input FIFO and a valid/ready handshake.
// It supports configurable data width, parity and stop bits.
// Queued words are sent back-to-back, with the next start bit directly after the last stop bit.
module uart_tx_stream #(
  parameter int CLK_FREQ   = 50000000,
  parameter int UART_BPS   = 9600,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          I_clk,
  input  logic                          I_rst,
  input  logic [DATA_BITS-1:0]          I_data,
  input  logic                          I_valid,
  output logic                          O_ready,
  output logic                          O_txd,
  output logic                          O_busy,
  output logic [$clog2(FIFO_DEPTH):0]   O_fifo_count
);

  localparam int BPS_CNT = CLK_FREQ / UART_BPS;
  localparam int CNT_W   = (BPS_CNT > 1) ? $clog2(BPS_CNT) : 1;
  localparam int BIT_W   = $clog2(DATA_BITS + 1);
  localparam int ADDR_W  = $clog2(FIFO_DEPTH);
  localparam int LVL_W   = ADDR_W + 1;

  localparam logic [CNT_W-1:0] CLK_LAST  = CNT_W'(BPS_CNT - 1);
  localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_BITS - 1);
  localparam logic [BIT_W-1:0] STOP_LAST = BIT_W'(STOP_BITS - 1);
  localparam logic [LVL_W-1:0] FIFO_FULL = LVL_W'(FIFO_DEPTH);
  localparam logic             PAR_ODD   = (PARITY == 1);
  localparam logic             HAS_PAR   = (PARITY != 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  // FIFO storage and bookkeeping
  logic [DATA_BITS-1:0] fifo_mem [FIFO_DEPTH];
  logic [ADDR_W-1:0]    wr_ptr;
  logic [ADDR_W-1:0]    rd_ptr;
  logic [LVL_W-1:0]     fifo_count;
  logic [DATA_BITS-1:0] fifo_rdata;
  logic                 fifo_empty;
  logic                 push;
  logic                 pop;

  // Transmit FSM state and next-state values
  state_t               state, state_next;
  logic [CNT_W-1:0]     clk_cnt, clk_cnt_next;
  logic [BIT_W-1:0]     bit_cnt, bit_cnt_next;
  logic [DATA_BITS-1:0] shift_reg, shift_next;
  logic                 par_bit, par_next;
  logic                 txd_next;
  logic                 busy_next;
  logic                 start_frame;
  logic                 bit_tick;

  assign O_ready      = (fifo_count != FIFO_FULL);
  assign O_fifo_count = fifo_count;
  assign push         = I_valid & O_ready;
  assign fifo_empty   = (fifo_count == '0);
  assign fifo_rdata   = fifo_mem[rd_ptr];
  assign bit_tick     = (clk_cnt == CLK_LAST);

  // Write accepted words into FIFO storage; contents need no reset because the count gates reads
  always_ff @(posedge I_clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= I_data;
    end
  end

  // Advance pointers and keep the occupancy count; a simultaneous push and pop cancel out
  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + LVL_W'(1);
        2'b01:   fifo_count <= fifo_count - LVL_W'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Register the FSM state, counters and line outputs so that O_txd and O_busy come from flops
  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      state     <= S_IDLE;
      clk_cnt   <= '0;
      bit_cnt   <= '0;
      shift_reg <= '0;
      par_bit   <= 1'b0;
      O_txd     <= 1'b1;
      O_busy    <= 1'b0;
    end else begin
      state     <= state_next;
      clk_cnt   <= clk_cnt_next;
      bit_cnt   <= bit_cnt_next;
      shift_reg <= shift_next;
      par_bit   <= par_next;
      O_txd     <= txd_next;
      O_busy    <= busy_next;
    end
  end

  // Next-state logic: time each bit, then pop and load the next word from IDLE or at the end of STOP
  always_comb begin
    state_next   = state;
    clk_cnt_next = clk_cnt;
    bit_cnt_next = bit_cnt;
    shift_next   = shift_reg;
    par_next     = par_bit;
    start_frame  = 1'b0;
    pop          = 1'b0;

    case (state)
      S_IDLE: begin
        clk_cnt_next = '0;
        bit_cnt_next = '0;
        if (!fifo_empty) begin
          start_frame = 1'b1;
        end
      end

      S_START: begin
        if (bit_tick) begin
          clk_cnt_next = '0;
          bit_cnt_next = '0;
          state_next   = S_DATA;
        end else begin
          clk_cnt_next = clk_cnt + 1'b1;
        end
      end

      S_DATA: begin
        if (bit_tick) begin
          clk_cnt_next = '0;
          shift_next   = shift_reg >> 1;
          if (bit_cnt == DATA_LAST) begin
            bit_cnt_next = '0;
            state_next   = HAS_PAR ? S_PARITY : S_STOP;
          end else begin
            bit_cnt_next = bit_cnt + 1'b1;
          end
        end else begin
          clk_cnt_next = clk_cnt + 1'b1;
        end
      end

      S_PARITY: begin
        if (bit_tick) begin
          clk_cnt_next = '0;
          bit_cnt_next = '0;
          state_next   = S_STOP;
        end else begin
          clk_cnt_next = clk_cnt + 1'b1;
        end
      end

      S_STOP: begin
        if (bit_tick) begin
          clk_cnt_next = '0;
          if (bit_cnt == STOP_LAST) begin
            bit_cnt_next = '0;
            if (!fifo_empty) begin
              start_frame = 1'b1;
            end else begin
              state_next = S_IDLE;
            end
          end else begin
            bit_cnt_next = bit_cnt + 1'b1;
          end
        end else begin
          clk_cnt_next = clk_cnt + 1'b1;
        end
      end

      default: begin
        state_next   = S_IDLE;
        clk_cnt_next = '0;
        bit_cnt_next = '0;
      end
    endcase

    if (start_frame) begin
      pop          = 1'b1;
      shift_next   = fifo_rdata;
      par_next     = (^fifo_rdata) ^ PAR_ODD;
      clk_cnt_next = '0;
      bit_cnt_next = '0;
      state_next   = S_START;
    end
  end

  // Choose the line level for the upcoming state so that the registered output lines up with bit boundaries
  always_comb begin
    txd_next  = 1'b1;
    busy_next = (state_next != S_IDLE);
    case (state_next)
      S_START:  txd_next = 1'b0;
      S_DATA:   txd_next = shift_next[0];
      S_PARITY: txd_next = par_next;
      default:  txd_next = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_stream.sv
// tb_uart_tx_stream: directed checks of uart_tx_stream in several configurations (BPS_CNT = 10).
module tb_uart_tx_stream;

  logic       clock;
  logic       reset;
  logic [7:0] data_bus;
  logic [4:0] valid_vec;
  int         sel;
  int         check_count;
  int         error_count;

  logic       txd_a, busy_a, ready_a;
  logic [4:0] count_a;
  logic       txd_b, busy_b, ready_b;
  logic [4:0] count_b;
  logic       txd_c, busy_c, ready_c;
  logic [4:0] count_c;
  logic       txd_d, busy_d, ready_d;
  logic [4:0] count_d;
  logic       txd_e, busy_e, ready_e;
  logic [2:0] count_e;

  logic        txd_sel, busy_sel, ready_sel;
  logic [31:0] count_sel;

  uart_tx_stream #(.CLK_FREQ(1000), .UART_BPS(100)) u_a (
    .I_clk(clock), .I_rst(reset), .I_data(data_bus), .I_valid(valid_vec[0]),
    .O_ready(ready_a), .O_txd(txd_a), .O_busy(busy_a), .O_fifo_count(count_a));

  uart_tx_stream #(.CLK_FREQ(1000), .UART_BPS(100), .PARITY(2)) u_b (
    .I_clk(clock), .I_rst(reset), .I_data(data_bus), .I_valid(valid_vec[1]),
    .O_ready(ready_b), .O_txd(txd_b), .O_busy(busy_b), .O_fifo_count(count_b));

  uart_tx_stream #(.CLK_FREQ(1000), .UART_BPS(100), .PARITY(1)) u_c (
    .I_clk(clock), .I_rst(reset), .I_data(data_bus), .I_valid(valid_vec[2]),
    .O_ready(ready_c), .O_txd(txd_c), .O_busy(busy_c), .O_fifo_count(count_c));

  uart_tx_stream #(.CLK_FREQ(1000), .UART_BPS(100), .DATA_BITS(5), .STOP_BITS(2)) u_d (
    .I_clk(clock), .I_rst(reset), .I_data(data_bus[4:0]), .I_valid(valid_vec[3]),
    .O_ready(ready_d), .O_txd(txd_d), .O_busy(busy_d), .O_fifo_count(count_d));

  uart_tx_stream #(.CLK_FREQ(1000), .UART_BPS(100), .FIFO_DEPTH(4)) u_e (
    .I_clk(clock), .I_rst(reset), .I_data(data_bus), .I_valid(valid_vec[4]),
    .O_ready(ready_e), .O_txd(txd_e), .O_busy(busy_e), .O_fifo_count(count_e));

  // Free-running clock, 10 ns period
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Route the instance under test onto a common set of observed signals
  always_comb begin
    txd_sel   = 1'b1;
    busy_sel  = 1'b0;
    ready_sel = 1'b0;
    count_sel = '0;
    case (sel)
      0: begin txd_sel = txd_a; busy_sel = busy_a; ready_sel = ready_a; count_sel = 32'(count_a); end
      1: begin txd_sel = txd_b; busy_sel = busy_b; ready_sel = ready_b; count_sel = 32'(count_b); end
      2: begin txd_sel = txd_c; busy_sel = busy_c; ready_sel = ready_c; count_sel = 32'(count_c); end
      3: begin txd_sel = txd_d; busy_sel = busy_d; ready_sel = ready_d; count_sel = 32'(count_d); end
      4: begin txd_sel = txd_e; busy_sel = busy_e; ready_sel = ready_e; count_sel = 32'(count_e); end
      default: ;
    endcase
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    check_count++;
    if (got !== exp) begin
      error_count++;
      $display("[TB] FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Walk a frame bit by bit (10 cycles each), checking the first and last cycle of every bit.
  // skip = cycles of bit 0 already elapsed at entry (entry is on a falling edge).
  task automatic checkFrame(input string tag, input logic [15:0] bits, input int nbits, input int skip);
    for (int i = 0; i < nbits; i++) begin
      if (i > 0 || skip == 0) begin
        checkOutput($sformatf("%s_b%0d_first", tag, i), {31'b0, txd_sel}, {31'b0, bits[i]});
      end
      checkOutput($sformatf("%s_b%0d_busy", tag, i), {31'b0, busy_sel}, 32'd1);
      repeat (9 - ((i == 0) ? skip : 0)) @(negedge clock);
      checkOutput($sformatf("%s_b%0d_last", tag, i), {31'b0, txd_sel}, {31'b0, bits[i]});
      @(negedge clock);
    end
  endtask

  // Push one word into an idle instance and check pop latency, the whole frame and the return to idle
  task automatic applyStimulus(input int s, input logic [7:0] d, input logic [15:0] bits,
                               input int nbits, input string tag);
    @(negedge clock);
    sel          = s;
    data_bus     = d;
    valid_vec[s] = 1'b1;
    @(posedge clock);
    @(negedge clock);
    valid_vec[s] = 1'b0;
    checkOutput({tag, "_cnt_after_push"}, count_sel, 32'd1);
    checkOutput({tag, "_txd_before_pop"}, {31'b0, txd_sel}, 32'd1);
    @(negedge clock);
    checkOutput({tag, "_cnt_after_pop"}, count_sel, 32'd0);
    checkFrame(tag, bits, nbits, 0);
    checkOutput({tag, "_busy_end"}, {31'b0, busy_sel}, 32'd0);
    checkOutput({tag, "_txd_end"}, {31'b0, txd_sel}, 32'd1);
  endtask

  // Safety net so the run always ends
  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [7:0]  words [6];
    int          exp_cnt [6];
    logic        exp_rdy [6];
    logic [15:0] bits;
    logic [7:0]  x0;
    logic        saw_low;

    words   = '{8'h31, 8'hC2, 8'h5A, 8'h0F, 8'hE7, 8'h99};
    exp_cnt = '{1, 1, 2, 3, 4, 4};
    exp_rdy = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

    check_count = 0;
    error_count = 0;
    sel         = 0;
    data_bus    = '0;
    valid_vec   = '0;
    reset       = 1'b1;

    // Reset / idle state
    repeat (3) @(posedge clock);
    @(negedge clock);
    checkOutput("rst_txd",   {31'b0, txd_sel},   32'd1);
    checkOutput("rst_busy",  {31'b0, busy_sel},  32'd0);
    checkOutput("rst_ready", {31'b0, ready_sel}, 32'd1);
    checkOutput("rst_count", count_sel,          32'd0);
    reset = 1'b0;

    // 8N1 0x55: start, data LSB first, stop
    bits = {6'b0, 1'b1, 8'h55, 1'b0};
    applyStimulus(0, 8'h55, bits, 10, "a55");

    // Even parity 0x03 gives parity 0; odd parity 0x03 and 0x00 give parity 1
    bits = {5'b0, 1'b1, 1'b0, 8'h03, 1'b0};
    applyStimulus(1, 8'h03, bits, 11, "even03");
    bits = {5'b0, 1'b1, 1'b1, 8'h03, 1'b0};
    applyStimulus(2, 8'h03, bits, 11, "odd03");
    bits = {5'b0, 1'b1, 1'b1, 8'h00, 1'b0};
    applyStimulus(2, 8'h00, bits, 11, "odd00");

    // Five data bits with two stop bits
    bits = {8'b0, 2'b11, 5'h1F, 1'b0};
    applyStimulus(3, 8'h1F, bits, 8, "w5s2");

    // FIFO full and back-to-back: six words offered, the last is rejected
    @(negedge clock);
    sel          = 4;
    valid_vec[4] = 1'b1;
    for (int k = 0; k < 6; k++) begin
      data_bus = words[k];
      @(posedge clock);
      @(negedge clock);
      checkOutput($sformatf("fill_cnt%0d", k), count_sel, 32'(exp_cnt[k]));
      checkOutput($sformatf("fill_rdy%0d", k), {31'b0, ready_sel}, {31'b0, exp_rdy[k]});
    end
    valid_vec[4] = 1'b0;
    for (int f = 0; f < 5; f++) begin
      if (f > 0) begin
        checkOutput($sformatf("b2b_cnt%0d", f), count_sel, 32'(4 - f));
      end
      bits = {6'b0, 1'b1, words[f], 1'b0};
      checkFrame($sformatf("b2b_f%0d", f), bits, 10, (f == 0) ? 4 : 0);
    end
    checkOutput("b2b_busy_end", {31'b0, busy_sel}, 32'd0);
    checkOutput("b2b_cnt_end",  count_sel,         32'd0);
    saw_low = 1'b0;
    repeat (30) begin
      @(negedge clock);
      if (txd_sel == 1'b0) saw_low = 1'b1;
    end
    checkOutput("b2b_no_extra_frame", {31'b0, saw_low}, 32'd0);

    // Reset during data bit 3 of a frame with two words still queued
    x0 = 8'h37;
    @(negedge clock);
    valid_vec[4] = 1'b1;
    data_bus     = x0;
    @(posedge clock);
    @(negedge clock);
    data_bus = 8'h48;
    @(posedge clock);
    @(negedge clock);
    data_bus = 8'h81;
    @(posedge clock);
    @(negedge clock);
    valid_vec[4] = 1'b0;
    checkOutput("mid_cnt_before", count_sel, 32'd2);
    repeat (44) @(negedge clock);
    checkOutput("mid_bit3", {31'b0, txd_sel}, {31'b0, x0[3]});
    reset = 1'b1;
    @(negedge clock);
    checkOutput("mid_rst_txd",   {31'b0, txd_sel},   32'd1);
    checkOutput("mid_rst_busy",  {31'b0, busy_sel},  32'd0);
    checkOutput("mid_rst_count", count_sel,          32'd0);
    checkOutput("mid_rst_ready", {31'b0, ready_sel}, 32'd1);
    reset   = 1'b0;
    saw_low = 1'b0;
    repeat (150) begin
      @(negedge clock);
      if (txd_sel == 1'b0) saw_low = 1'b1;
    end
    checkOutput("mid_no_frames", {31'b0, saw_low}, 32'd0);
    bits = {6'b0, 1'b1, 8'h6B, 1'b0};
    applyStimulus(4, 8'h6B, bits, 10, "after_rst");

    $display("CHECKS %0d ERRORS %0d", check_count, error_count);
    $finish;
  end

endmodule

// File: doc/uart_tx_stream.md
# uart_tx_stream

Parametrised UART transmitter with an input FIFO and valid/ready handshake. Generalises the fixed 8N1, edge-triggered transmitter to configurable data width, parity and stop bits. Queued bytes are sent back-to-back without software pacing. Sits between any byte/word producer in the fabric and the board TX pin.

## Interface
Parameters:
- CLK_FREQ, 50000000, system clock frequency in Hz
- UART_BPS, 9600, baud rate; BPS_CNT = CLK_FREQ/UART_BPS (integer division, must be ≥ 2)
- DATA_BITS, 8, data bits per frame, legal 5..9
- PARITY, 0, 0 = none, 1 = odd, 2 = even
- STOP_BITS, 1, legal 1 or 2
- FIFO_DEPTH, 16, entries, power of two ≥ 2

Ports (one clock; reset is synchronous and active-high):
- I_clk  in  1  system clock, all logic on rising edge
- I_rst  in  1  synchronous active-high reset
- I_data  in  DATA_BITS  word to transmit, LSB sent first
- I_valid  in  1  producer offers I_data this cycle
- O_ready  out  1  FIFO can accept; transfer when I_valid & O_ready at a rising edge
- O_txd  out  1  UART serial output, idle high
- O_busy  out  1  a frame is on the line (start bit through end of last stop bit)
- O_fifo_count  out  $clog2(FIFO_DEPTH)+1  words queued, not including the word being shifted

## Operation
- FIFO: push on I_valid & O_ready; O_ready = (O_fifo_count != FIFO_DEPTH), combinational from registered count. Pop only from FSM. Simultaneous push and pop leave count unchanged. I_valid while O_ready low is ignored; the word is not captured.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE: O_txd = 1. If FIFO not empty: pop, load shift register, compute parity, go START.
- START: O_txd = 0 for BPS_CNT cycles, then DATA.
- DATA: O_txd = shift[0], shift right every BPS_CNT cycles. After DATA_BITS bits, go PARITY if PARITY != 0, else STOP.
- Parity bit value: odd → total ones in data plus parity is odd; even → total is even. Parity lasts one bit period.
- STOP: O_txd = 1 for STOP_BITS × BPS_CNT cycles, full periods, no early release.
  - At the end, if FIFO is non-empty: pop and enter START directly, with zero idle cycles between frames.
  - Otherwise go IDLE.
- Bit counter: clk_cnt counts 0..BPS_CNT-1, width $clog2(BPS_CNT). bit_cnt counts bits within the current state, width $clog2(DATA_BITS+1).
- Reset: FIFO flushed, pointers and count 0, state IDLE, all counters 0, O_txd = 1, O_busy = 0, O_ready = 1. Applies mid-frame too: the line goes high on the next edge and the frame is truncated.

## Timing
- O_txd and O_busy are registered outputs.
- Latency: word accepted at edge N into an empty FIFO with FSM in IDLE → pop at edge N+1. O_txd = 0 and O_busy = 1 are visible after edge N+1.
- Frame length = (1 + DATA_BITS + (PARITY!=0) + STOP_BITS) × BPS_CNT cycles, exactly.
- Each bit lasts exactly BPS_CNT cycles; O_txd changes only on bit boundaries.
- Back-to-back: the first start-bit cycle of frame k+1 immediately follows the last stop-bit cycle of frame k.
- O_busy falls on the edge that returns the FSM to IDLE.
- O_fifo_count updates on the edge after a push or pop.

## Test plan
- Reset/idle: CLK_FREQ=1000, UART_BPS=100 (BPS_CNT=10), hold I_rst 3 cycles → O_txd=1, O_busy=0, O_ready=1, O_fifo_count=0.
- 8N1 single word: push 0x55 → O_txd low 1 cycle after the push. Line reads 0,1,0,1,0,1,0,1,0,1 (start, LSB-first data, stop), each bit 10 cycles. 100-cycle frame, then O_busy=0.
- Parity: PARITY=2, push 0x03 → parity bit 0. PARITY=1, push 0x03 → parity bit 1. PARITY=1, push 0x00 → parity bit 1. Frame = 110 cycles.
- Width and stop bits: DATA_BITS=5, STOP_BITS=2, push 0x1F → start 0, five 1s, stop high for 20 cycles. 80-cycle frame.
- FIFO full/back-to-back: FIFO_DEPTH=4, push 6 words with I_valid held high.
  - Required: O_ready drops when count reaches 4 and rejected words are not sent.
  - Exactly 5 frames are sent: 1 popped immediately plus 4 queued.
  - No idle cycle between frames; the bytes arrive in push order.
- Reset mid-frame: assert I_rst during DATA bit 3 of frame 1 with 2 words queued.
  - Required: O_txd=1 on the next edge, count 0, no further frames.
  - A new push after reset transmits normally.
